any1_ibuf: RTL and testbench
============================

Name: any1_ibuf

Overview:
- Instruction queue directly downstream of the instruction aligner; consumes one aligned instruction per cycle and feeds the decode stage.
- Decouples fetch from decode stalls with a small circular FIFO.
- Carries ir, ip, pip, Stream and predict_taken unchanged.
- Supports a single-cycle flush on redirect or mispredict.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, minimum 2.
- IR_W, 64, instruction register width.
- AW, 32, instruction pointer width, used for ip and pip.
- SW, 5, Stream tag width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discard all entries and the incoming instruction.
- in_valid_i  in  1  aligner output is valid.
- in_ready_o  out  1  queue accepts a push.
- in_ir_i  in  IR_W  aligned instruction; alignment-fault encoding passes through untouched.
- in_ip_i  in  AW  instruction pointer.
- in_pip_i  in  AW  previous instruction pointer.
- in_stream_i  in  SW  stream tag.
- in_pt_i  in  1  predict_taken.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  decode accepts the head entry.
- out_ir_o  out  IR_W  head instruction.
- out_ip_o  out  AW  head instruction pointer.
- out_pip_o  out  AW  head previous instruction pointer.
- out_stream_o  out  SW  head stream tag.
- out_pt_o  out  1  head predict_taken.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst_ni low, asynchronous): read and write pointers 0, count_o 0, out_valid_o 0, all out_* data 0, in_ready_o 1 once reset is released.
- Pointers are $clog2(DEPTH)+1 bits wide. The extra MSB distinguishes full from empty.
  - empty: pointers equal.
  - full: indices equal and MSBs differ.
  - Wrap-around is natural modulo 2*DEPTH.
- Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- in_ready_o = !full. It is combinational from registered pointers only, with no path from out_ready_i.
  - When full, no push occurs even if a pop happens in the same cycle.
- out_valid_o = !empty. Head fields are read from storage indexed by the registered read pointer, so they are stable while out_valid_o is high and no pop occurs.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N (1-cycle latency when the queue is empty).
- Simultaneous push and pop when not full and not empty: both take effect and count is unchanged.
- Push and pop on a 1-entry queue: the new entry becomes the head in the next cycle.
- Pop when empty or push when full: impossible by handshake. An assertion flags any write of storage while full.
- flush_i (synchronous, highest priority): at the next edge both pointers are zeroed and count becomes 0. Any push or pop in the same cycle is ignored.
  - The cycle after the flush: out_valid_o 0, in_ready_o 1.
- Storage data is not cleared on flush; only pointers are.
- count_o = wr_ptr - rd_ptr, modulo 2*DEPTH.

Optional Feature:
- Macro: ANY1_IBUF_BYPASS_EN.
- Defined: when the queue is empty and flush_i is low, in_* drives out_* combinationally and out_valid_o = in_valid_i.
  - If out_ready_i is high in that cycle, the entry is consumed without being written and the pointers are unchanged.
  - Otherwise it is written normally.
  - Empty-queue latency is 0. in_ready_o is still independent of out_ready_i.
- Not defined: behaviour exactly as above, with a 1-cycle minimum latency and no combinational in-to-out path.

Decomposition:
- any1_pkg gains the typedef sInstBufEntry {ir, ip, pip, Stream, predict_taken}, matching the aligner output field set, plus the constant IBUF_DEPTH = 4.
- Sub-module any1_ibuf_ptr: pointer register with increment, wrap and synchronous clear. It is instantiated twice, once for the read pointer and once for the write pointer.
- Storage is an inline register array of sInstBufEntry.

Test Plan:
- Reset, then push ip=0x100, 0x104, 0x108 with out_ready_i=0.
  - Expected: count_o=3, out_ip_o=0x100, in_ready_o=1.
  - Push 0x10C: count_o=4, in_ready_o=0.
- Hold a 5th push (ip=0x110) at full while popping one.
  - Expected: no push that cycle, count_o=3, out_ip_o=0x104.
  - The next cycle accepts 0x110, count_o=4.
- Continuous push and pop for 10 cycles starting from 0x200.
  - Expected: out_ip_o sequence 0x200, 0x204, … in order, count_o steady at 1 after fill, pointers wrap without loss.
- With 3 entries, assert flush_i together with in_valid_i (ip=0x300) and out_ready_i.
  - Expected: next cycle count_o=0, out_valid_o=0, and 0x300 never appears.
- Push ir=alignment-fault word with Stream=3 and predict_taken=1.
  - Expected: all fields emerge bit-identical.
- Assert rst_ni low mid-stream with 2 entries.
  - Expected: outputs zero immediately (asynchronous), count_o=0.
- With ANY1_IBUF_BYPASS_EN defined, push 0x400 into an empty queue with out_ready_i=1.
  - Expected: out_ip_o=0x400 in the same cycle, count_o stays 0.

Source files
------------

// File: rtl/any1_pkg.sv
// Shared any1 front-end types: the instruction-buffer entry and its default depth.
package any1_pkg;

  localparam int ANY1_IR_W  = 64;
  localparam int ANY1_AW    = 32;
  localparam int ANY1_SW    = 5;
  localparam int IBUF_DEPTH = 4;

  // Same field set the aligner produces.
  typedef struct packed {
    logic [ANY1_IR_W-1:0] ir;
    logic [ANY1_AW-1:0]   ip;
    logic [ANY1_AW-1:0]   pip;
    logic [ANY1_SW-1:0]   Stream;
    logic                 predict_taken;
  } sInstBufEntry;

endpackage

// File: rtl/any1_ibuf_ptr.sv
// Circular-buffer pointer: increments with natural wrap, synchronous clear
// overrides increment, asynchronous active-low reset.
module any1_ibuf_ptr #(
  parameter int PW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/any1_ibuf.sv
// Instruction queue between the aligner and decode. Optional macro
// ANY1_IBUF_BYPASS_EN adds a zero-latency empty-queue path from in_* to out_*.
module any1_ibuf
  import any1_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int IR_W  = ANY1_IR_W,
  parameter int AW    = ANY1_AW,
  parameter int SW    = ANY1_SW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [IR_W-1:0]          in_ir_i,
  input  logic [AW-1:0]            in_ip_i,
  input  logic [AW-1:0]            in_pip_i,
  input  logic [SW-1:0]            in_stream_i,
  input  logic                     in_pt_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [IR_W-1:0]          out_ir_o,
  output logic [AW-1:0]            out_ip_o,
  output logic [AW-1:0]            out_pip_o,
  output logic [SW-1:0]            out_stream_o,
  output logic                     out_pt_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  sInstBufEntry  r_mem [DEPTH];
  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_wr_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_en;
  sInstBufEntry  w_in_entry;
  sInstBufEntry  w_head;

  assign w_empty = (w_rd_ptr == w_wr_ptr);
  assign w_full  = (w_rd_ptr[IW-1:0] == w_wr_ptr[IW-1:0]) &&
                   (w_rd_ptr[IW] != w_wr_ptr[IW]);

  assign in_ready_o = !w_full;
  assign count_o    = w_wr_ptr - w_rd_ptr;

  always_comb begin
    w_in_entry               = '0;
    w_in_entry.ir            = in_ir_i;
    w_in_entry.ip            = in_ip_i;
    w_in_entry.pip           = in_pip_i;
    w_in_entry.Stream        = in_stream_i;
    w_in_entry.predict_taken = in_pt_i;
  end

`ifdef ANY1_IBUF_BYPASS_EN
  logic w_bypass;
  logic w_consumed;

  assign w_bypass    = w_empty && !flush_i;
  // An entry taken straight through by decode never touches storage.
  assign w_consumed  = w_bypass && in_valid_i && out_ready_i;
  assign out_valid_o = w_empty ? (in_valid_i && !flush_i) : 1'b1;
  assign w_push      = in_valid_i && in_ready_o && !w_consumed;
  assign w_pop       = !w_empty && out_ready_i;

  always_comb begin
    w_head = '0;
    if (!w_empty)      w_head = r_mem[w_rd_ptr[IW-1:0]];
    else if (w_bypass) w_head = w_in_entry;
  end
`else
  assign out_valid_o = !w_empty;
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  // Head is forced to zero when empty so reset and flush present clean outputs.
  always_comb begin
    w_head = '0;
    if (!w_empty) w_head = r_mem[w_rd_ptr[IW-1:0]];
  end
`endif

  assign w_wr_en = w_push && !flush_i;

  assign out_ir_o     = w_head.ir;
  assign out_ip_o     = w_head.ip;
  assign out_pip_o    = w_head.pip;
  assign out_stream_o = w_head.Stream;
  assign out_pt_o     = w_head.predict_taken;

  any1_ibuf_ptr #(.PW(PW)) u_rd_ptr (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (flush_i),
    .i_inc   (w_pop),
    .o_ptr   (w_rd_ptr)
  );

  any1_ibuf_ptr #(.PW(PW)) u_wr_ptr (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (flush_i),
    .i_inc   (w_push),
    .o_ptr   (w_wr_ptr)
  );

  // Storage is data-only: never reset, never cleared by flush.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_wr_ptr[IW-1:0]] <= w_in_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && w_wr_en) assert (!w_full);
  end

endmodule

// File: tb/tb_any1_ibuf.sv
// Directed bench for any1_ibuf: fill/full, pop-at-full, streaming with wrap,
// flush, field transparency, asynchronous reset and the optional bypass.
module tb_any1_ibuf;

  localparam int DEPTH = 4;
  localparam int IR_W  = 64;
  localparam int AW    = 32;
  localparam int SW    = 5;
  localparam logic [IR_W-1:0] FAULT_IR = 64'hFFFF_FFFF_FFFF_FF3F;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [IR_W-1:0] in_ir_i = '0;
  logic [AW-1:0]   in_ip_i = '0;
  logic [AW-1:0]   in_pip_i = '0;
  logic [SW-1:0]   in_stream_i = '0;
  logic            in_pt_i = 1'b0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [IR_W-1:0] out_ir_o;
  logic [AW-1:0]   out_ip_o;
  logic [AW-1:0]   out_pip_o;
  logic [SW-1:0]   out_stream_o;
  logic            out_pt_o;
  logic [2:0]      count_o;

  int n_vec = 0;
  int n_err = 0;

  any1_ibuf #(.DEPTH(DEPTH), .IR_W(IR_W), .AW(AW), .SW(SW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_ir_i      (in_ir_i),
    .in_ip_i      (in_ip_i),
    .in_pip_i     (in_pip_i),
    .in_stream_i  (in_stream_i),
    .in_pt_i      (in_pt_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_ir_o     (out_ir_o),
    .out_ip_o     (out_ip_o),
    .out_pip_o    (out_pip_o),
    .out_stream_o (out_stream_o),
    .out_pt_o     (out_pt_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] ip);
    in_valid_i = v;
    in_ip_i    = ip;
    in_pip_i   = ip - 32'd4;
    in_ir_i    = {32'h0, ip};
  endtask

  initial begin
    #2;
    chk("rst_count", count_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ip", out_ip_o, 0);
    chk("rst_ir", out_ir_o, 0);
    #5 rst_ni = 1'b1;
    #1 chk("rst_ready", in_ready_o, 1);
    tick();

    // Fill to three, then to full
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k));
      tick();
    end
    drive(1'b0, '0);
    chk("fill3_count", count_o, 3);
    chk("fill3_head", out_ip_o, 32'h100);
    chk("fill3_ready", in_ready_o, 1);
    chk("fill3_valid", out_valid_o, 1);
    drive(1'b1, 32'h10C);
    tick();
    chk("full_count", count_o, 4);
    chk("full_ready", in_ready_o, 0);

    // Push held at full while popping: push must wait a cycle
    drive(1'b1, 32'h110);
    out_ready_i = 1'b1;
    tick();
    chk("popfull_count", count_o, 3);
    chk("popfull_head", out_ip_o, 32'h104);
    out_ready_i = 1'b0;
    tick();
    chk("retry_count", count_o, 4);
    drive(1'b0, '0);

    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_head", out_ip_o, 32'h104 + 32'(4 * k));
      tick();
    end
    out_ready_i = 1'b0;
    chk("drain_valid", out_valid_o, 0);
    chk("drain_count", count_o, 0);

    // Streaming push+pop, pointers wrap several times
    out_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k));
      if (k > 0) begin
        chk("stream_head", out_ip_o, 32'h200 + 32'(4 * (k - 1)));
        chk("stream_count", count_o, 1);
      end
      tick();
    end
    drive(1'b0, '0);
    chk("stream_last", out_ip_o, 32'h224);
    tick();
    chk("stream_empty", count_o, 0);
    out_ready_i = 1'b0;

    // Flush with concurrent push and pop
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h280 + 32'(4 * k));
      tick();
    end
    chk("preflush_count", count_o, 3);
    drive(1'b1, 32'h300);
    out_ready_i = 1'b1;
    flush_i     = 1'b1;
    tick();
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b0, '0);
    chk("flush_count", count_o, 0);
    chk("flush_valid", out_valid_o, 0);
    chk("flush_ready", in_ready_o, 1);
    chk("flush_ip", out_ip_o, 0);
    drive(1'b1, 32'h304);
    tick();
    drive(1'b0, '0);
    chk("postflush_count", count_o, 1);
    chk("postflush_head", out_ip_o, 32'h304);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("postflush_empty", out_valid_o, 0);

    // Field transparency for an alignment-fault word
    in_valid_i  = 1'b1;
    in_ir_i     = FAULT_IR;
    in_ip_i     = 32'hDEAD_BEE0;
    in_pip_i    = 32'h0000_03FC;
    in_stream_i = 5'd3;
    in_pt_i     = 1'b1;
    tick();
    drive(1'b0, '0);
    in_stream_i = '0;
    in_pt_i     = 1'b0;
    chk("fault_ir", out_ir_o, FAULT_IR);
    chk("fault_ip", out_ip_o, 32'hDEAD_BEE0);
    chk("fault_pip", out_pip_o, 32'h0000_03FC);
    chk("fault_stream", out_stream_o, 3);
    chk("fault_pt", out_pt_o, 1);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;

    // Asynchronous reset mid-stream
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h380 + 32'(4 * k));
      tick();
    end
    drive(1'b0, '0);
    chk("prerst_count", count_o, 2);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_valid", out_valid_o, 0);
    chk("arst_ip", out_ip_o, 0);
    chk("arst_ir", out_ir_o, 0);
    #3 rst_ni = 1'b1;
    tick();
    chk("arst_ready", in_ready_o, 1);

`ifdef ANY1_IBUF_BYPASS_EN
    drive(1'b1, 32'h400);
    out_ready_i = 1'b1;
    #1;
    chk("byp_valid", out_valid_o, 1);
    chk("byp_ip", out_ip_o, 32'h400);
    tick();
    drive(1'b0, '0);
    out_ready_i = 1'b0;
    chk("byp_count", count_o, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
